sobel_line_buffer: RTL and testbench
====================================

# sobel_line_buffer

Raster-to-window front end for the Sobel datapath: accepts one pixel per valid cycle in raster order and emits three vertically aligned pixels (same column, three consecutive rows) on every valid output cycle. It is the producer side of the three-row tap interface: its `dout1/dout2/dout3` drive the `din1/din2/din3` inputs of the 3x3 gradient block. Two internal line memories hold the previous two rows. Output is suppressed until two full rows are stored.

## Interface
- `WIDTH`, 24, pixel width in bits (packed RGB/grey replicated).
- `PIC_WIDTH`, 640, pixels per row.
- `PIC_HEIGHT`, 480, rows per frame.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  `din` is a valid pixel this cycle.
- `din`  in  WIDTH  pixel at current (row, col).
- `valid_out`  out  1  `dout1..3` are a valid column triple.
- `dout1`  out  WIDTH  pixel at (row-2, col), oldest row.
- `dout2`  out  WIDTH  pixel at (row-1, col).
- `dout3`  out  WIDTH  pixel at (row, col), current row.
- `eof_out`  out  1  one-cycle pulse with the last valid output of a frame.

## Operation
- Counters:
  - `col` in [0, PIC_WIDTH-1], advances only on `valid_in`, wraps to 0 and increments `row`.
  - `row` in [0, PIC_HEIGHT-1], wraps to 0 after the last pixel of the frame.
- Fill state, derived from `row`:
  - PRIME0 when row==0.
  - PRIME1 when row==1.
  - STREAM when row>=2.
  - The frame wrap returns the block to PRIME0.
- Line memory A holds row-1 and line memory B holds row-2, each PIC_WIDTH deep.
  - Read is synchronous with 1-cycle latency.
  - A read of an address being written in the same cycle returns the old data.
- On each `valid_in` at column c:
  - Read A[c] and B[c].
  - Write A[c] <= `din`.
- One cycle later, B[c_d] <= A read data, where c_d is the registered column. This propagates row-1 into the row-2 store.
- Outputs (registered): `dout3` = delayed `din`, `dout2` = A read data, `dout1` = B read data.
- Cycles with `valid_in` low:
  - Counters hold.
  - No memory writes.
  - `dout*` hold their values.
  - `valid_out` = 0.
- Memory contents are not cleared on reset or frame wrap. Validity comes only from the PRIME gating.
- Arithmetic: `col` is clog2(PIC_WIDTH) bits and `row` is clog2(PIC_HEIGHT) bits. Compares use full width with no truncation.

## Timing
- Reset values: `valid_out`=0, `eof_out`=0, `dout1..3`=0, `col`=0, `row`=0.
- Latency is 1 cycle from `valid_in`/`din` to `valid_out`/`dout*`.
- `valid_out`(t+1) = `valid_in`(t) AND (`row`(t) >= 2).
- `eof_out`(t+1) = `valid_in`(t) AND row==PIC_HEIGHT-1 AND col==PIC_WIDTH-1.
- Throughput is one pixel per cycle sustained. Arbitrary `valid_in` gaps are allowed anywhere, including mid-row, with no loss of alignment.
- The B write from the previous pixel and the A/B reads for the current pixel hit different addresses. Back-to-back same-address access occurs only when PIC_WIDTH==1, which is unsupported (PIC_WIDTH >= 2).
- Reset mid-frame:
  - Next cycle all outputs are 0 and counters are 0.
  - The next pixel is treated as (0,0).
  - Two rows are re-primed before `valid_out` rises.
- There is no backpressure; the downstream consumer must accept every `valid_out` cycle.

## Structure
- Shared package `sobel_pkg`:
  - Default `WIDTH`, `PIC_WIDTH`, `PIC_HEIGHT` constants.
  - Pixel typedef.
  - The same constants used by the gradient block, so both agree on geometry.
- One sub-module, `line_ram`:
  - Simple dual-port, parameterised depth and width.
  - One write port and one synchronous read port, read-old-on-collision.
  - Instantiated twice (A, B); must infer block RAM.
- The top level holds the counters, PRIME/STREAM decode, delay registers, and output registers.

## Test plan
Use PIC_WIDTH=4, PIC_HEIGHT=4, WIDTH=24. Each pixel value is row*16+col, e.g. (2,1)=0x21.

1. Assert `rst` for 2 cycles with `valid_in`=1 -> every output is 0 during and one cycle after reset.
2. Stream the first 8 pixels continuously (rows 0 and 1) -> `valid_out` stays 0 throughout.
3. Apply pixel (2,0)=0x20 -> next cycle `valid_out`=1, `dout1`=0x00, `dout2`=0x10, `dout3`=0x20. Pixel (3,3) gives 0x13/0x23/0x33 together with `eof_out`=1.
4. Drop `valid_in` for 5 cycles after (3,1), then resume -> `valid_out`=0 and `dout*` hold 0x11/0x21/0x31 during the gap. Pixel (3,2) then yields 0x12/0x22/0x32.
5. Start a second frame with values +0x80 -> `valid_out` is 0 for its first 8 pixels. Pixel (2,0) yields 0x80/0x90/0xA0, with no leakage from frame 1.
6. Pulse `rst` for one cycle after pixel (3,0) -> outputs are 0 the next cycle. The next 8 pixels give no `valid_out`, and the 9th pixel produces correctly aligned output.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared geometry and pixel types for the Sobel datapath.
// Line buffer and gradient block both import these defaults.
package sobel_pkg;

    localparam int SOBEL_WIDTH      = 24;
    localparam int SOBEL_PIC_WIDTH  = 640;
    localparam int SOBEL_PIC_HEIGHT = 480;

    typedef logic [SOBEL_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        FILL_PRIME0 = 2'd0,
        FILL_PRIME1 = 2'd1,
        FILL_STREAM = 2'd2
    } fill_e;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line memory, one write and one registered read port.
// A read of the address written in the same cycle returns the old word.
module line_ram #(
    parameter int DEPTH = 640,
    parameter int DW    = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Array kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_line_buffer.sv
// Raster-to-column front end: emits (row-2, row-1, row) pixel triples
// once two full rows of the frame are held in the line memories.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int WIDTH      = SOBEL_WIDTH,
    parameter int PIC_WIDTH  = SOBEL_PIC_WIDTH,
    parameter int PIC_HEIGHT = SOBEL_PIC_HEIGHT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             eof_out
);

    localparam int CW = $clog2(PIC_WIDTH);
    localparam int RW = $clog2(PIC_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    b_addr_q, b_addr_d;
    logic             b_we_q, b_we_d;
    logic [WIDTH-1:0] dout3_q, dout3_d;
    logic             valid_q, valid_d;
    logic             eof_q, eof_d;

    fill_e            fill;
    logic             pix_en;
    logic             last_px;
    logic [WIDTH-1:0] a_rd;
    logic [WIDTH-1:0] b_rd;

    always_comb begin
        fill = FILL_STREAM;
        unique case (1'b1)
            (row_q == RW'(0)): fill = FILL_PRIME0;
            (row_q == RW'(1)): fill = FILL_PRIME1;
            default:           fill = FILL_STREAM;
        endcase
    end

    assign pix_en  = valid_in & ~rst;
    assign last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Row-1 word read from A this cycle is copied into B next cycle.
    always_comb begin
        b_we_d   = valid_in;
        b_addr_d = col_q;
        dout3_d  = valid_in ? din : dout3_q;
        valid_d  = valid_in && (fill == FILL_STREAM);
        eof_d    = valid_in && last_px;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            b_addr_q <= '0;
            b_we_q   <= 1'b0;
            dout3_q  <= '0;
            valid_q  <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            b_addr_q <= b_addr_d;
            b_we_q   <= b_we_d;
            dout3_q  <= dout3_d;
            valid_q  <= valid_d;
            eof_q    <= eof_d;
        end
    end

    line_ram #(
        .DEPTH (PIC_WIDTH),
        .DW    (WIDTH),
        .AW    (CW)
    ) u_ram_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (pix_en),
        .waddr_i (col_q),
        .wdata_i (din),
        .re_i    (pix_en),
        .raddr_i (col_q),
        .rdata_o (a_rd)
    );

    line_ram #(
        .DEPTH (PIC_WIDTH),
        .DW    (WIDTH),
        .AW    (CW)
    ) u_ram_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (b_we_q & ~rst),
        .waddr_i (b_addr_q),
        .wdata_i (a_rd),
        .re_i    (pix_en),
        .raddr_i (col_q),
        .rdata_o (b_rd)
    );

    assign valid_out = valid_q;
    assign eof_out   = eof_q;
    assign dout1     = b_rd;
    assign dout2     = a_rd;
    assign dout3     = dout3_q;

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Scoreboard bench for sobel_line_buffer on a 4x4 frame.
// Expected triples come from a stored image of the current frame.
module tb_sobel_line_buffer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] din;
    logic          valid_out;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;
    logic [DW-1:0] dout3;
    logic          eof_out;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] d3;
        logic          eof;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] img [H][W];
    int            mr = 0;
    int            mc = 0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    sobel_line_buffer #(
        .WIDTH      (DW),
        .PIC_WIDTH  (W),
        .PIC_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .din       (din),
        .valid_out (valid_out),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .eof_out   (eof_out)
    );

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: pixel (r,c) pairs with the same column of the two rows above.
    task automatic send(input logic [DW-1:0] v);
        valid_in = 1'b1;
        din      = v;
        if (mr >= 2)
            q.push_back('{img[mr-2][mc], img[mr-1][mc], v,
                          (mr == H-1 && mc == W-1)});
        img[mr][mc] = v;
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic gap(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, DW'(valid_out), '0);
        chk({name, "_eof"}, DW'(eof_out), '0);
        chk({name, "_d1"}, dout1, '0);
        chk({name, "_d2"}, dout2, '0);
        chk({name, "_d3"}, dout3, '0);
    endtask

    task automatic do_rst(input int n);
        rst      = 1'b1;
        valid_in = 1'b1;
        din      = DW'($urandom());
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk_zero("rst");
        end
        rst      = 1'b0;
        valid_in = 1'b0;
        mr       = 0;
        mc       = 0;
    endtask

    task automatic chk_tri(input string name, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        chk({name, "_valid"}, DW'(valid_out), DW'(1));
        chk({name, "_d1"}, dout1, e1);
        chk({name, "_d2"}, dout2, e2);
        chk({name, "_d3"}, dout3, e3);
    endtask

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got valid_out=1 want no output");
            end else begin
                e = q.pop_front();
                if (dout1 !== e.d1 || dout2 !== e.d2 ||
                    dout3 !== e.d3 || eof_out !== e.eof) begin
                    bad++;
                    $display("FAIL sb_triple: got %h/%h/%h eof=%b want %h/%h/%h eof=%b",
                             dout1, dout2, dout3, eof_out,
                             e.d1, e.d2, e.d3, e.eof);
                end
            end
        end else if (eof_out === 1'b1) begin
            total++;
            bad++;
            $display("FAIL sb_eof: got eof_out=1 with valid_out=0 want 0");
        end
    end

    initial begin
        rst      = 1'b1;
        valid_in = 1'b1;
        din      = '0;

        do_rst(2);
        gap(1);
        chk_zero("post_rst");

        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) begin
                send(DW'(r * 16 + c));
                chk("prime_valid", DW'(valid_out), '0);
            end

        send(DW'(8'h20));
        chk_tri("first", DW'(8'h00), DW'(8'h10), DW'(8'h20));
        send(DW'(8'h21));
        send(DW'(8'h22));
        send(DW'(8'h23));
        send(DW'(8'h30));
        send(DW'(8'h31));

        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b0;
            @(posedge clk);
            #1;
            chk("gap_valid", DW'(valid_out), '0);
            chk("gap_d1", dout1, DW'(8'h11));
            chk("gap_d2", dout2, DW'(8'h21));
            chk("gap_d3", dout3, DW'(8'h31));
        end

        send(DW'(8'h32));
        chk_tri("resume", DW'(8'h12), DW'(8'h22), DW'(8'h32));
        send(DW'(8'h33));
        chk_tri("last", DW'(8'h13), DW'(8'h23), DW'(8'h33));
        chk("last_eof", DW'(eof_out), DW'(1));
        gap(1);
        chk("eof_pulse", DW'(eof_out), '0);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(DW'(8'h80 + r * 16 + c));
                if (r < 2)
                    chk("f2_prime", DW'(valid_out), '0);
                if (r == 2 && c == 0)
                    chk_tri("f2_first", DW'(8'h80), DW'(8'h90), DW'(8'hA0));
            end

        for (int k = 0; k < 13; k++)
            send(DW'(8'h40 + (k / W) * 16 + (k % W)));
        do_rst(1);
        for (int k = 0; k < W * H; k++) begin
            send(DW'(8'hC0 + (k / W) * 16 + (k % W)));
            if (k < 8)
                chk("rerst_prime", DW'(valid_out), '0);
            if (k == 8)
                chk_tri("rerst_first", DW'(8'hC0), DW'(8'hD0), DW'(8'hE0));
        end

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0)
                gap($urandom_range(1, 3));
            if ($urandom_range(0, 99) == 0)
                do_rst(1);
            send(DW'($urandom()));
        end

        gap(3);
        chk("drain", DW'(q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
